score_sender: RTL and testbench
===============================

SCORE_SENDER -- requirements
Module: score_sender

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 20, meaning the cycles btn must be stable before an edge is accepted.
REQ-002 SHALL have parameter GAP_CYCLES, default 8, meaning the minimum number of idle cycles between successive submit pulses.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of pending scores buffered (power of 2).
REQ-004 SHALL have port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  input  1  the asynchronous, active-low reset.
REQ-006 SHALL have port sw  input  4  the raw score switches, sampled when a press is accepted.
REQ-007 SHALL have port btn  input  1  the raw, asynchronous, bouncing submit button, active-high.
REQ-008 SHALL have port scorein  output  4  the score presented to the downstream judging block.
REQ-009 SHALL have port submit  output  1  the one-cycle strobe qualifying scorein.
REQ-010 SHALL have port full  output  1  high while the FIFO holds FIFO_DEPTH entries.
REQ-011 SHALL have port drop  output  1  a one-cycle pulse when a press is rejected.
REQ-012 SHALL have port sent_cnt  output  3  the saturating count of submits sent, held at 7.

Function
REQ-013 btn SHALL pass through a 2-flop synchronizer, then a debouncer; the debounced level SHALL change only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-014 A press SHALL be accepted only on a 0->1 edge of the debounced level.
REQ-015 On an accepted press, sw SHALL be registered that cycle; a value of 0, or full high, SHALL drop the press and pulse drop; otherwise the value SHALL be pushed to the FIFO.
REQ-016 The transmit FSM SHALL have states IDLE, LOAD, STROBE and GAP.
REQ-017 In IDLE with the FIFO non-empty, the FSM SHALL pop the FIFO into scorein and go to LOAD.
REQ-018 LOAD SHALL last one cycle with scorein stable and submit low, then go to STROBE.
REQ-019 STROBE SHALL assert submit for exactly one cycle, increment sent_cnt (saturating at 7), then go to GAP.
REQ-020 GAP SHALL hold submit low for GAP_CYCLES cycles, then return to IDLE.
REQ-021 scorein SHALL hold its last value until the next LOAD.
REQ-022 Latency from a push into an empty FIFO while in IDLE SHALL be pop +1 cycle, LOAD +1 cycle, with submit high on the 3rd cycle after the push.
REQ-023 A push and a pop in the same cycle SHALL both take effect, leaving the occupancy unchanged; with full high, this same-cycle case SHALL still reject the push.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be derived from a log2(FIFO_DEPTH)+1-bit occupancy count.
REQ-025 A held button SHALL produce one press only; the next press requires a debounced release first.

Reset
REQ-026 Asserting rst_n low SHALL immediately force scorein=0, submit=0, full=0, drop=0 and sent_cnt=0, FSM=IDLE, the FIFO empty, and the debouncer and synchronizer to 0.
REQ-027 A reset mid-STROBE or mid-GAP SHALL abort the transfer with no further submit, and queued scores SHALL be discarded.
REQ-028 After deassertion, a btn held high SHALL not count as a press until released and pressed again.

Structure
REQ-029 The state encoding (IDLE/LOAD/STROBE/GAP), MAX_SCORE=15 and SENT_MAX=7 SHALL live in the shared package score_pkg.
REQ-030 The debouncer SHALL be a separate sub-module, btn_debounce (clk, rst_n, raw, level), instantiated once.
REQ-031 The FIFO SHALL be inline in score_sender.

Verification
REQ-032 Single press: sw=9, btn pulsed with 5 bounces then held 40 cycles -> exactly one submit with scorein=9 and sent_cnt=1.
REQ-033 Burst: presses with sw=3,7,12,15 in quick succession -> four submits in order 3,7,12,15, each separated by at least GAP_CYCLES+2 cycles.
REQ-034 Overflow: 5 presses (sw=1..5) while the FSM is held in GAP with FIFO_DEPTH=4 -> the 5th press pulses drop, full is high, and only 1..4 are sent.
REQ-035 Zero score: sw=0 press -> drop pulses once, with no submit and sent_cnt unchanged.
REQ-036 Saturation and reset: 9 valid presses -> sent_cnt stops at 7; rst_n low during STROBE -> submit drops low asynchronously and the FIFO is empty after release.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and limits for the score sender: transmit FSM encoding,
// score/counter widths and the saturating submit counter helper.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STROBE = 2'd2,
    GAP    = 2'd3
  } tx_state_e;

  localparam int MAX_SCORE = 15;
  localparam int SENT_MAX  = 7;
  localparam int SCORE_W   = $clog2(MAX_SCORE + 1);
  localparam int SENT_W    = $clog2(SENT_MAX + 1);

  function automatic logic [SENT_W-1:0] sat_inc(input logic [SENT_W-1:0] v);
    return (v == SENT_W'(SENT_MAX)) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Debouncer for an already-synchronized button: the output level follows the
// input only after DEBOUNCE_CYCLES consecutive samples that differ from it.
module btn_debounce
  import score_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (raw == level_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      level_q <= raw;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/score_sender.sv
// Button-driven score submitter: debounced presses capture the switches into a
// small FIFO, drained by a LOAD/STROBE/GAP transmit FSM toward the judge.
module score_sender
  import score_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int GAP_CYCLES      = 8,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SCORE_W-1:0] sw,
  input  logic               btn,
  output logic [SCORE_W-1:0] scorein,
  output logic               submit,
  output logic               full,
  output logic               drop,
  output logic [SENT_W-1:0]  sent_cnt
);

  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int ARM_CYCLES = DEBOUNCE_CYCLES + 2;
  localparam int ARM_W      = $clog2(ARM_CYCLES + 1);
  localparam int GW         = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [1:0]         sync_q;
  logic               btn_level;
  logic               level_prev_q;
  logic               armed_q;
  logic [ARM_W-1:0]   arm_cnt_q;
  logic               press;
  logic               cap_vld_q;
  logic [SCORE_W-1:0] cap_sw_q;
  logic               drop_q;

  logic [SCORE_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count_q, count_d;
  logic               push, pop, fifo_full, fifo_empty;

  tx_state_e          state_q;
  logic [GW-1:0]      gap_q;
  logic [SCORE_W-1:0] scorein_q;
  logic               submit_q;
  logic [SENT_W-1:0]  sent_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (sync_q[1]),
    .level(btn_level)
  );

  // Presses are ignored until the button has been seen released long enough,
  // so a button held through reset does not fire on its own.
  assign press = armed_q & btn_level & ~level_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      level_prev_q <= 1'b0;
      armed_q      <= 1'b0;
      arm_cnt_q    <= '0;
      cap_vld_q    <= 1'b0;
      cap_sw_q     <= '0;
      drop_q       <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], btn};
      level_prev_q <= btn_level;
      if (!armed_q) begin
        if (sync_q[1])
          arm_cnt_q <= '0;
        else if (arm_cnt_q == ARM_W'(ARM_CYCLES - 1))
          armed_q <= 1'b1;
        else
          arm_cnt_q <= arm_cnt_q + 1'b1;
      end
      cap_vld_q <= press;
      if (press)
        cap_sw_q <= sw;
      drop_q <= cap_vld_q && ((cap_sw_q == '0) || fifo_full);
    end
  end

  assign fifo_full  = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = cap_vld_q && (cap_sw_q != '0) && !fifo_full;
  assign pop        = (state_q == IDLE) && !fifo_empty;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (pop && !push)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= cap_sw_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // scorein is only ever loaded on a pop, so it holds between transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      scorein_q <= '0;
      submit_q  <= 1'b0;
      sent_q    <= '0;
    end else begin
      submit_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            scorein_q <= mem_q[rd_ptr_q];
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          submit_q <= 1'b1;
          sent_q   <= sat_inc(sent_q);
          state_q  <= STROBE;
        end
        STROBE: begin
          gap_q   <= '0;
          state_q <= GAP;
        end
        GAP: begin
          if (gap_q == GW'(GAP_CYCLES - 1))
            state_q <= IDLE;
          else
            gap_q <= gap_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign scorein  = scorein_q;
  assign submit   = submit_q;
  assign full     = fifo_full;
  assign drop     = drop_q;
  assign sent_cnt = sent_q;

endmodule

// File: tb/tb_score_sender.sv
// Directed bench for score_sender: short debounce and a long gap so the FIFO
// can be filled while the transmitter is parked in GAP.
module tb_score_sender;

  localparam int DEB     = 4;
  localparam int GAPC    = 150;
  localparam int SPACING = GAPC + 3;  // STROBE, GAP x GAPC, IDLE, LOAD, STROBE

  logic       clk;
  logic       rst_n;
  logic [3:0] sw;
  logic       btn;
  logic [3:0] scorein;
  logic       submit;
  logic       full;
  logic       drop;
  logic [2:0] sent_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int drop_cnt = 0;
  int drop_full = 0;
  int sub_v[$];
  int sub_t[$];
  int sub_n[$];

  score_sender #(
    .DEBOUNCE_CYCLES(DEB),
    .GAP_CYCLES     (GAPC),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw      (sw),
    .btn     (btn),
    .scorein (scorein),
    .submit  (submit),
    .full    (full),
    .drop    (drop),
    .sent_cnt(sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (submit === 1'b1) begin
      sub_v.push_back(int'(scorein));
      sub_t.push_back(cyc);
      sub_n.push_back(int'(sent_cnt));
      $display("submit score=%0d sent_cnt=%0d cycle=%0d", scorein, sent_cnt, cyc);
    end
    if (drop === 1'b1) begin
      drop_cnt  <= drop_cnt + 1;
      drop_full <= int'(full);
      $display("drop full=%0d cycle=%0d", full, cyc);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] v, input int bounces, input int hold);
    sw = v;
    for (int i = 0; i < bounces; i++) begin
      btn = 1'b1; tick(1);
      btn = 1'b0; tick(1);
    end
    btn = 1'b1;
    tick(hold);
    for (int i = 0; i < bounces; i++) begin
      btn = 1'b0; tick(1);
      btn = 1'b1; tick(1);
    end
    btn = 1'b0;
    tick(10);
  endtask

  task automatic wait_subs(input int n, input int budget);
    int k = 0;
    while (sub_v.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check("submit_count", sub_v.size(), n);
  endtask

  initial begin
    int k;
    int c0;
    rst_n = 1'b1;
    btn   = 1'b0;
    sw    = 4'd0;
    #3 rst_n = 1'b0;
    #20;
    check("rst_scorein", scorein, 0);
    check("rst_submit", submit, 0);
    check("rst_full", full, 0);
    check("rst_drop", drop, 0);
    check("rst_sent", sent_cnt, 0);
    tick(2);
    rst_n = 1'b1;
    tick(20);

    // single bouncy press
    press(4'd9, 5, 40);
    wait_subs(1, 100);
    tick(30);
    check("single_count", sub_v.size(), 1);
    check("single_score", sub_v[0], 9);
    check("single_sent", sub_n[0], 1);

    // zero score is dropped
    press(4'd0, 0, 10);
    tick(5);
    check("zero_drop", drop_cnt, 1);
    check("zero_nosub", sub_v.size(), 1);
    check("zero_sent", sent_cnt, 1);

    // burst
    press(4'd3, 0, 10);
    press(4'd7, 0, 10);
    press(4'd12, 0, 10);
    press(4'd15, 0, 10);
    wait_subs(5, 1000);
    check("burst_s0", sub_v[1], 3);
    check("burst_s1", sub_v[2], 7);
    check("burst_s2", sub_v[3], 12);
    check("burst_s3", sub_v[4], 15);
    check("burst_sent", sub_n[4], 5);
    for (int i = 2; i <= 4; i++)
      check("burst_spacing", sub_t[i] - sub_t[i-1], SPACING);
    check("burst_nodrop", drop_cnt, 1);

    // overflow while parked in GAP after the last burst submit
    for (int v = 1; v <= 5; v++)
      press(4'(v), 0, 10);
    check("ovf_drop", drop_cnt, 2);
    check("ovf_full_at_drop", drop_full, 1);
    check("ovf_full", full, 1);
    wait_subs(9, 800);
    for (int i = 0; i < 4; i++)
      check("ovf_order", sub_v[5+i], i + 1);
    check("sat_sent_6", sub_n[5], 6);
    check("sat_sent_7", sub_n[6], 7);
    check("sat_sent_hold", sub_n[8], 7);
    tick(200);
    check("ovf_fifth_not_sent", sub_v.size(), 9);
    check("ovf_empty", full, 0);

    // reset during STROBE with a score still queued
    press(4'd5, 0, 10);
    press(4'd10, 0, 10);
    press(4'd11, 0, 10);
    k = 0;
    @(negedge clk);
    while (!(submit === 1'b1 && scorein == 4'd10) && k < 600) begin
      @(negedge clk);
      k++;
    end
    #2;
    check("strobe_seen", submit, 1);
    check("strobe_sent_sat", sent_cnt, 7);
    rst_n = 1'b0;
    btn   = 1'b1;
    sw    = 4'd7;
    #1;
    check("arst_submit", submit, 0);
    check("arst_sent", sent_cnt, 0);
    check("arst_scorein", scorein, 0);
    check("arst_full", full, 0);
    tick(3);
    rst_n = 1'b1;
    tick(400);
    check("held_btn_no_press", sub_v.size(), 11);
    check("held_btn_no_drop", drop_cnt, 2);
    check("post_rst_empty", full, 0);

    // clean press after release: btn rise to submit latency
    btn = 1'b0;
    tick(15);
    btn = 1'b1;
    c0 = cyc;
    tick(10);
    btn = 1'b0;
    tick(10);
    wait_subs(12, 200);
    check("rearm_score", sub_v[11], 7);
    check("rearm_sent", sub_n[11], 1);
    check("rearm_latency", sub_t[11] - c0, 2 + DEB + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
